pkt_tx_framer: RTL and testbench

- Transmit-side counterpart of the node's receive packet filter.
- Accepts a one-shot build request (packet type, destination, up to four payload words) from the control blocks: myNodeInfo, knownCH, reward, findMyBest.
- Serialises the request into a 16-bit word stream toward the radio/MAC interface using a valid/ready handshake.
- Frame layout matches what the receive path decodes, so fPktType and destinationID come back out unchanged at the far node.

---
 rtl/pkt_tx_framer_pkg.sv | 44 ++++
 rtl/pkt_hdr_enc.sv | 20 ++
 rtl/pkt_tx_framer.sv | 118 +++++++++++
 tb/tb_pkt_tx_framer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_tx_framer_pkg.sv
// Shared packet definitions for the transmit framer and the receive packet filter.
// Type encodings, header field positions and payload lengths live here only.
package pkt_defs;

  localparam int WORD_WIDTH  = 16;
  localparam int MAX_PAYLOAD = 4;
  localparam logic [15:0] BCAST_ID = 16'hFFFF;

  localparam logic [2:0] PKT_HB      = 3'b000;
  localparam logic [2:0] PKT_CHE     = 3'b001;
  localparam logic [2:0] PKT_INV     = 3'b010;
  localparam logic [2:0] PKT_MR      = 3'b011;
  localparam logic [2:0] PKT_CHT     = 3'b100;
  localparam logic [2:0] PKT_DATA    = 3'b101;
  localparam logic [2:0] PKT_SOS     = 3'b110;
  localparam logic [2:0] PKT_ILLEGAL = 3'b111;

  localparam int HDR_TYPE_MSB  = 15;
  localparam int HDR_TYPE_LSB  = 13;
  localparam int HDR_LEN_MSB   = 12;
  localparam int HDR_LEN_LSB   = 10;
  localparam int HDR_BCAST_BIT = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } framer_state_t;

  // Illegal types report zero payload words; the framer never sends them.
  function automatic logic [2:0] len_of(input logic [2:0] pkt_type);
    case (pkt_type)
      PKT_HB:   len_of = 3'd4;
      PKT_CHE:  len_of = 3'd1;
      PKT_INV:  len_of = 3'd3;
      PKT_MR:   len_of = 3'd1;
      PKT_CHT:  len_of = 3'd1;
      PKT_DATA: len_of = 3'd2;
      PKT_SOS:  len_of = 3'd2;
      default:  len_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/pkt_hdr_enc.sv
// Combinational header encoder: packet type and destination to header word and
// payload length.
module pkt_hdr_enc
  import pkt_defs::*;
(
  input  logic [2:0]  pkt_type,
  input  logic [15:0] dest,
  output logic [15:0] hdr,
  output logic [2:0]  len
);

  always_comb begin
    len = len_of(pkt_type);
    hdr = '0;
    hdr[HDR_TYPE_MSB:HDR_TYPE_LSB] = pkt_type;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    hdr[HDR_BCAST_BIT]             = (dest == BCAST_ID);
  end

endmodule

// File: rtl/pkt_tx_framer.sv
// Transmit framer: captures one build request and streams header, source,
// destination and payload words over a valid/ready interface.
module pkt_tx_framer
  import pkt_defs::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [15:0] req_dest,
  input  logic [63:0] req_payload,
  input  logic [15:0] myNodeID,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] tx_data,
  output logic        tx_last,
  output logic        busy,
  output logic        err_type,
  output logic [15:0] frames_sent
);

  framer_state_t state;
  logic [2:0]  cap_type;
  logic [15:0] cap_dest;
  logic [15:0] cap_src;
  logic [63:0] cap_payload;
  logic [2:0]  idx;

  logic [15:0] hdr;
  logic [2:0]  len;
  logic [2:0]  last_idx;
  logic [2:0]  nxt_idx;
  logic [15:0] next_word;

  pkt_hdr_enc u_hdr_enc (
    .pkt_type (cap_type),
    .dest     (cap_dest),
    .hdr      (hdr),
    .len      (len)
  );

  assign busy      = (state != ST_IDLE);
  assign req_ready = !busy;
  assign last_idx  = 3'd2 + len;
  assign nxt_idx   = idx + 3'd1;

  // Word 0 is loaded in LOAD, so only indices 1..6 need selecting here.
  always_comb begin
    next_word = '0;
    case (nxt_idx)
      3'd1:    next_word = cap_src;
      3'd2:    next_word = cap_dest;
      3'd3:    next_word = cap_payload[15:0];
      3'd4:    next_word = cap_payload[31:16];
      3'd5:    next_word = cap_payload[47:32];
      3'd6:    next_word = cap_payload[63:48];
      default: next_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      cap_type    <= '0;
      cap_dest    <= '0;
      cap_src     <= '0;
      cap_payload <= '0;
      idx         <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      tx_last     <= 1'b0;
      err_type    <= 1'b0;
      frames_sent <= '0;
    end else begin
      err_type <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_type == PKT_ILLEGAL) begin
              err_type <= 1'b1;
            end else begin
              cap_type    <= req_type;
              cap_dest    <= req_dest;
              cap_src     <= myNodeID;
              cap_payload <= req_payload;
              state       <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          tx_valid <= 1'b1;
          tx_data  <= hdr;
          tx_last  <= 1'b0;
          idx      <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (idx == last_idx) begin
              tx_valid    <= 1'b0;
              tx_last     <= 1'b0;
              tx_data     <= '0;
              frames_sent <= frames_sent + 16'd1;
              state       <= ST_IDLE;
            end else begin
              idx     <= nxt_idx;
              tx_data <= next_word;
              tx_last <= (nxt_idx == last_idx);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Directed self-checking bench for pkt_tx_framer; outputs sampled on negedge,
// inputs driven on negedge.
module tb_pkt_tx_framer;

  logic        clk;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [15:0] req_dest;
  logic [63:0] req_payload;
  logic [15:0] myNodeID;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        busy;
  logic        err_type;
  logic [15:0] frames_sent;

  int testsRun;
  int testsFailed;
  logic [15:0] expWords [7];

  pkt_tx_framer dut (
    .clk         (clk),
    .nrst        (nrst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_type    (req_type),
    .req_dest    (req_dest),
    .req_payload (req_payload),
    .myNodeID    (myNodeID),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .busy        (busy),
    .err_type    (err_type),
    .frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] ptype,
                               input logic [15:0] dest, input logic [63:0] payload,
                               input logic [15:0] src);
    req_valid   = valid;
    req_type    = ptype;
    req_dest    = dest;
    req_payload = payload;
    myNodeID    = src;
  endtask

  // Entered on the negedge just after the accepting edge (LOAD cycle).
  // readyMode 0: tx_ready always 1; readyMode 1: tx_ready pattern 1,0,0,1.
  task automatic runFrame(input string tag, input int n, input int readyMode);
    int got;
    int cyc;
    logic stalled;
    logic [15:0] heldData;
    logic heldLast;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    heldData = '0;
    heldLast = 1'b0;
    checkOutput({tag, "_load_valid"}, tx_valid, 16'd0);
    checkOutput({tag, "_load_busy"}, busy, 16'd1);
    checkOutput({tag, "_load_ready"}, req_ready, 16'd0);
    @(posedge clk);
    @(negedge clk);
    while (got < n && cyc < 60) begin
      tx_ready = (readyMode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      if (stalled) begin
        checkOutput({tag, "_stall_valid"}, tx_valid, 16'd1);
        checkOutput({tag, "_stall_data"}, tx_data, heldData);
        checkOutput({tag, "_stall_last"}, tx_last, heldLast);
      end
      if (tx_valid) begin
        if (tx_ready) begin
          checkOutput($sformatf("%s_w%0d", tag, got), tx_data, expWords[got]);
          checkOutput($sformatf("%s_last%0d", tag, got), tx_last, (got == n - 1));
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          heldData = tx_data;
          heldLast = tx_last;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (got < n) checkOutput({tag, "_timeout_words"}, got[15:0], n[15:0]);
    checkOutput({tag, "_end_valid"}, tx_valid, 16'd0);
    checkOutput({tag, "_end_busy"}, busy, 16'd0);
    tx_ready = 1'b1;
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    nrst = 1'b0;
    tx_ready = 1'b1;
    applyStimulus(1'b0, 3'b000, 16'h0000, 64'h0, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 16'd1);
    checkOutput("rst_tx_valid", tx_valid, 16'd0);
    checkOutput("rst_tx_data", tx_data, 16'h0000);
    checkOutput("rst_tx_last", tx_last, 16'd0);
    checkOutput("rst_busy", busy, 16'd0);
    checkOutput("rst_err_type", err_type, 16'd0);
    checkOutput("rst_frames", frames_sent, 16'd0);
    nrst = 1'b1;
    @(negedge clk);

    // HB broadcast, 7 words; inputs scrambled after accept to prove capture.
    expWords = '{16'h1200, 16'h0005, 16'hFFFF, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    applyStimulus(1'b1, 3'b000, 16'hFFFF, 64'h0004_0003_0002_0001, 16'h0005);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 3'b110, 16'h1234, 64'hDEAD_BEEF_CAFE_F00D, 16'h7777);
    runFrame("hb", 7, 0);
    checkOutput("hb_frames", frames_sent, 16'd1);

    // INV unicast with stalls; unused slot 3 must not appear.
    expWords = '{16'h4C00, 16'h0007, 16'h0012, 16'h0001, 16'h0002, 16'h0003, 16'h0000};
    applyStimulus(1'b1, 3'b010, 16'h0012, 64'h1111_0003_0002_0001, 16'h0007);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 16'h0000, 64'h0, 16'h0000);
    runFrame("inv", 6, 1);
    checkOutput("inv_frames", frames_sent, 16'd2);

    // Illegal type: single err_type pulse, nothing sent.
    applyStimulus(1'b1, 3'b111, 16'h0042, 64'h0, 16'h0007);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 16'h0000, 64'h0, 16'h0000);
    checkOutput("ill_err_pulse", err_type, 16'd1);
    checkOutput("ill_tx_valid", tx_valid, 16'd0);
    checkOutput("ill_req_ready", req_ready, 16'd1);
    checkOutput("ill_busy", busy, 16'd0);
    @(negedge clk);
    checkOutput("ill_err_clear", err_type, 16'd0);
    checkOutput("ill_tx_valid2", tx_valid, 16'd0);
    checkOutput("ill_frames", frames_sent, 16'd2);

    // Back-to-back DATA: second request held valid through the first frame.
    expWords = '{16'hA800, 16'h0009, 16'h0100, 16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000};
    applyStimulus(1'b1, 3'b101, 16'h0100, 64'h0000_0000_BBBB_AAAA, 16'h0009);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 3'b101, 16'h0200, 64'h0000_0000_DDDD_CCCC, 16'h0009);
    runFrame("data1", 5, 0);
    checkOutput("b2b_req_ready", req_ready, 16'd1);
    expWords = '{16'hA800, 16'h0009, 16'h0200, 16'hCCCC, 16'hDDDD, 16'h0000, 16'h0000};
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 16'h0000, 64'h0, 16'h0000);
    runFrame("data2", 5, 0);
    checkOutput("b2b_frames", frames_sent, 16'd4);

    // Reset while W3 of an HB frame is on the bus.
    expWords = '{16'h1200, 16'h0005, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    applyStimulus(1'b1, 3'b000, 16'hFFFF, 64'h0004_0003_0002_0001, 16'h0005);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 16'h0000, 64'h0, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("rstmid_w%0d", k), tx_data, expWords[k]);
    end
    nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    checkOutput("rstmid_tx_valid", tx_valid, 16'd0);
    checkOutput("rstmid_busy", busy, 16'd0);
    checkOutput("rstmid_req_ready", req_ready, 16'd1);
    checkOutput("rstmid_tx_last", tx_last, 16'd0);
    checkOutput("rstmid_frames", frames_sent, 16'd0);
    expWords = '{16'h2400, 16'h0021, 16'h0033, 16'h5A5A, 16'h0000, 16'h0000, 16'h0000};
    applyStimulus(1'b1, 3'b001, 16'h0033, 64'h9999_8888_7777_5A5A, 16'h0021);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 16'h0000, 64'h0, 16'h0000);
    runFrame("che", 4, 0);
    checkOutput("che_frames", frames_sent, 16'd1);

    // Counter wrap: preload to FFFF, one MR broadcast frame brings it to 0.
    force dut.frames_sent = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.frames_sent;
    @(negedge clk);
    checkOutput("wrap_preload", frames_sent, 16'hFFFF);
    expWords = '{16'h6600, 16'h0005, 16'hFFFF, 16'h1357, 16'h0000, 16'h0000, 16'h0000};
    applyStimulus(1'b1, 3'b011, 16'hFFFF, 64'h0000_0000_0000_1357, 16'h0005);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 16'h0000, 64'h0, 16'h0000);
    runFrame("mr", 4, 0);
    checkOutput("wrap_frames", frames_sent, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
